// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer: stage indices,
// hold encodings, FSM states and default widths.
package pipe_ctrl_pkg;

    localparam int NSTG      = 5;
    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_WB    = 4;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam int PC_W_DEF = 64;

    typedef logic [NSTG-1:0] stg_vec_t;

    // Front-end registers (pc_reg, if_id, id_ex) that a redirect takes over.
    localparam stg_vec_t FRONT_MASK  = 5'b00111;
    localparam stg_vec_t FLUSH_FRONT = 5'b00110;
    localparam stg_vec_t HOLD_PC     = 5'b00001;

    typedef enum logic {
        ST_RUN        = 1'b0,
        ST_WAIT_FETCH = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_prio_enc.sv
// Priority encoder: the oldest stalling stage holds itself and everything
// younger, and injects a bubble into the register just downstream of it.
module pipe_ctrl_stall_prio_enc
    import pipe_ctrl_pkg::*;
(
    input  logic     if_req_i,
    input  logic     id_req_i,
    input  logic     ex_req_i,
    input  logic     mem_req_i,
    output stg_vec_t stall_o,
    output stg_vec_t bubble_o
);

    always_comb begin
        stall_o  = '0;
        bubble_o = '0;
        if (mem_req_i) begin
            stall_o[STG_PC]    = STOP;
            stall_o[STG_IFID]  = STOP;
            stall_o[STG_IDEX]  = STOP;
            stall_o[STG_EXMEM] = STOP;
            bubble_o[STG_WB]   = STOP;
        end else if (ex_req_i) begin
            stall_o[STG_PC]     = STOP;
            stall_o[STG_IFID]   = STOP;
            stall_o[STG_IDEX]   = STOP;
            bubble_o[STG_EXMEM] = STOP;
        end else if (id_req_i) begin
            stall_o[STG_PC]    = STOP;
            stall_o[STG_IFID]  = STOP;
            bubble_o[STG_IDEX] = STOP;
        end else if (if_req_i) begin
            stall_o[STG_PC]    = STOP;
            bubble_o[STG_IFID] = STOP;
        end else begin
            stall_o  = {NSTG{NOSTOP}};
            bubble_o = {NSTG{NOSTOP}};
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer: combines stage stall requests and the EX
// redirect into hold/bubble vectors, with stall statistics and a watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int WDOG_LIMIT = 1024,
    parameter int CNT_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_stall_req_i,
    input  logic            id_stall_req_i,
    input  logic            ex_stall_req_i,
    input  logic            mem_stall_req_i,
    input  logic            if_busy_i,
    input  logic            ex_redir_valid_i,
    input  logic [PC_W-1:0] ex_redir_pc_i,
    output logic            ex_redir_ack_o,
    output logic [4:0]      stall_ctrl_o,
    output logic [4:0]      bubble_ctrl_o,
    output logic            pc_redir_valid_o,
    output logic [PC_W-1:0] pc_redir_addr_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic            watchdog_err_o
);

    localparam int WD_W = $clog2(WDOG_LIMIT + 1);

    ctrl_state_e     state_q, state_d;
    logic [PC_W-1:0] redir_q, redir_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            wdog_err_q, wdog_err_d;

    stg_vec_t enc_stall, enc_bubble;
    logic     redir_accept;
    logic     wdog_cond;

    pipe_ctrl_stall_prio_enc u_prio (
        .if_req_i  (if_stall_req_i),
        .id_req_i  (id_stall_req_i),
        .ex_req_i  (ex_stall_req_i),
        .mem_req_i (mem_stall_req_i),
        .stall_o   (enc_stall),
        .bubble_o  (enc_bubble)
    );

    // Only stalls at or beyond EX block a redirect; younger stalls are flushed by it.
    assign redir_accept = (state_q == ST_RUN) && ex_redir_valid_i
                          && !mem_stall_req_i && !ex_stall_req_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            redir_q <= redir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        redir_d = redir_q;
        case (state_q)
            ST_RUN: begin
                if (redir_accept && if_busy_i) begin
                    state_d = ST_WAIT_FETCH;
                    redir_d = ex_redir_pc_i;
                end
            end
            ST_WAIT_FETCH: begin
                if (!if_busy_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall_ctrl_o     = '0;
        bubble_ctrl_o    = '0;
        ex_redir_ack_o   = 1'b0;
        pc_redir_valid_o = 1'b0;
        pc_redir_addr_o  = '0;
        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    stall_ctrl_o  = enc_stall;
                    bubble_ctrl_o = enc_bubble;
                    if (redir_accept) begin
                        ex_redir_ack_o = 1'b1;
                        stall_ctrl_o   = enc_stall & ~FRONT_MASK;
                        bubble_ctrl_o  = enc_bubble | FLUSH_FRONT;
                        if (!if_busy_i) begin
                            pc_redir_valid_o = 1'b1;
                            pc_redir_addr_o  = ex_redir_pc_i;
                        end
                    end
                end
                ST_WAIT_FETCH: begin
                    // The in-flight fetch cannot be cancelled, so its result is discarded.
                    stall_ctrl_o  = (enc_stall & ~FRONT_MASK) | HOLD_PC;
                    bubble_ctrl_o = (enc_bubble & ~FRONT_MASK) | FLUSH_FRONT;
                    if (!if_busy_i) begin
                        pc_redir_valid_o = 1'b1;
                        pc_redir_addr_o  = redir_q;
                    end
                end
                default: begin
                    stall_ctrl_o  = '0;
                    bubble_ctrl_o = '0;
                end
            endcase
        end
    end

    assign wdog_cond = (stall_ctrl_o[STG_WB:STG_EXMEM] != 2'b00)
                       || (state_q == ST_WAIT_FETCH);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall_ctrl_o != '0) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        wdog_d = '0;
        if (wdog_cond) begin
            wdog_d = (wdog_q == WD_W'(WDOG_LIMIT)) ? wdog_q : wdog_q + WD_W'(1);
        end
        wdog_err_d = wdog_err_q || (wdog_d == WD_W'(WDOG_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            wdog_q      <= '0;
            wdog_err_q  <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            wdog_q      <= wdog_d;
            wdog_err_q  <= wdog_err_d;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign watchdog_err_o = wdog_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, redirect paths, counters,
// watchdog and reset out of WAIT_FETCH.
module tb_pipe_ctrl;

    localparam int PC_W       = 64;
    localparam int WDOG_LIMIT = 16;
    localparam int CNT_W      = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_stall_req, id_stall_req, ex_stall_req, mem_stall_req;
    logic            if_busy, ex_redir_valid;
    logic [PC_W-1:0] ex_redir_pc;
    logic            ex_redir_ack;
    logic [4:0]      stall_ctrl, bubble_ctrl;
    logic            pc_redir_valid;
    logic [PC_W-1:0] pc_redir_addr;
    logic [CNT_W-1:0] stall_cycles;
    logic            watchdog_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .PC_W       (PC_W),
        .WDOG_LIMIT (WDOG_LIMIT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .if_stall_req_i   (if_stall_req),
        .id_stall_req_i   (id_stall_req),
        .ex_stall_req_i   (ex_stall_req),
        .mem_stall_req_i  (mem_stall_req),
        .if_busy_i        (if_busy),
        .ex_redir_valid_i (ex_redir_valid),
        .ex_redir_pc_i    (ex_redir_pc),
        .ex_redir_ack_o   (ex_redir_ack),
        .stall_ctrl_o     (stall_ctrl),
        .bubble_ctrl_o    (bubble_ctrl),
        .pc_redir_valid_o (pc_redir_valid),
        .pc_redir_addr_o  (pc_redir_addr),
        .stall_cycles_o   (stall_cycles),
        .watchdog_err_o   (watchdog_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_comb(input string tag, input logic [4:0] s, input logic [4:0] b,
                            input logic ack, input logic pv);
        chk({tag, "_stall"}, 64'(stall_ctrl), 64'(s));
        chk({tag, "_bubble"}, 64'(bubble_ctrl), 64'(b));
        chk({tag, "_ack"}, 64'(ex_redir_ack), 64'(ack));
        chk({tag, "_pcv"}, 64'(pc_redir_valid), 64'(pv));
    endtask

    initial begin
        rst = 1'b1;
        {if_stall_req, id_stall_req, ex_stall_req, mem_stall_req} = 4'b0000;
        if_busy = 1'b0;
        ex_redir_valid = 1'b0;
        ex_redir_pc = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_comb("reset", 5'b00000, 5'b00000, 1'b0, 1'b0);
        chk("reset_addr", pc_redir_addr, 64'h0);
        chk("reset_cnt", 64'(stall_cycles), 64'd0);
        chk("reset_wd", 64'(watchdog_err), 64'd0);

        // Stall priority, oldest first
        {if_stall_req, id_stall_req, ex_stall_req, mem_stall_req} = 4'b1111;
        #1 chk_comb("prio_mem", 5'b01111, 5'b10000, 1'b0, 1'b0);
        tick();
        chk("cnt_after_one", 64'(stall_cycles), 64'd1);
        mem_stall_req = 1'b0;
        #1 chk_comb("prio_ex", 5'b00111, 5'b01000, 1'b0, 1'b0);
        tick();
        ex_stall_req = 1'b0;
        #1 chk_comb("prio_id", 5'b00011, 5'b00100, 1'b0, 1'b0);
        tick();
        id_stall_req = 1'b0;
        #1 chk_comb("prio_if", 5'b00001, 5'b00010, 1'b0, 1'b0);
        tick();
        if_stall_req = 1'b0;
        #1 chk_comb("prio_none", 5'b00000, 5'b00000, 1'b0, 1'b0);
        tick();
        chk("cnt_after_prio", 64'(stall_cycles), 64'd4);

        // Immediate redirect
        ex_redir_valid = 1'b1;
        ex_redir_pc = 64'h8000_0100;
        #1 chk_comb("redir_imm", 5'b00000, 5'b00110, 1'b1, 1'b1);
        chk("redir_imm_addr", pc_redir_addr, 64'h8000_0100);
        tick();
        ex_redir_valid = 1'b0;
        #1 chk_comb("redir_imm_after", 5'b00000, 5'b00000, 1'b0, 1'b0);

        // Redirect overrides a younger load-use stall
        id_stall_req = 1'b1;
        ex_redir_valid = 1'b1;
        ex_redir_pc = 64'h8000_0180;
        #1 chk_comb("redir_over_id", 5'b00000, 5'b00110, 1'b1, 1'b1);
        chk("redir_over_id_addr", pc_redir_addr, 64'h8000_0180);
        tick();
        id_stall_req = 1'b0;
        ex_redir_valid = 1'b0;
        #1 chk("cnt_after_redir", 64'(stall_cycles), 64'd4);

        // Redirect while a fetch is outstanding
        ex_redir_valid = 1'b1;
        ex_redir_pc = 64'h8000_0200;
        if_busy = 1'b1;
        #1 chk_comb("wait_ack", 5'b00000, 5'b00110, 1'b1, 1'b0);
        tick();
        ex_redir_pc = 64'h0000_0000_0001_2345;
        #1 chk_comb("wait_c1_noaccept", 5'b00001, 5'b00110, 1'b0, 1'b0);
        tick();
        ex_redir_valid = 1'b0;
        #1 chk_comb("wait_c2", 5'b00001, 5'b00110, 1'b0, 1'b0);
        tick();
        #1 chk_comb("wait_c3", 5'b00001, 5'b00110, 1'b0, 1'b0);
        tick();
        if_busy = 1'b0;
        #1 chk_comb("wait_release", 5'b00001, 5'b00110, 1'b0, 1'b1);
        chk("wait_release_addr", pc_redir_addr, 64'h8000_0200);
        tick();
        chk_comb("wait_back_run", 5'b00000, 5'b00000, 1'b0, 1'b0);
        chk("cnt_after_wait", 64'(stall_cycles), 64'd8);

        // Redirect blocked by a memory stall
        ex_redir_valid = 1'b1;
        ex_redir_pc = 64'h8000_0300;
        mem_stall_req = 1'b1;
        #1 chk_comb("blk_c1", 5'b01111, 5'b10000, 1'b0, 1'b0);
        tick();
        chk_comb("blk_c2", 5'b01111, 5'b10000, 1'b0, 1'b0);
        tick();
        mem_stall_req = 1'b0;
        #1 chk_comb("blk_release", 5'b00000, 5'b00110, 1'b1, 1'b1);
        chk("blk_release_addr", pc_redir_addr, 64'h8000_0300);
        tick();
        ex_redir_valid = 1'b0;
        #1 chk("cnt_after_blk", 64'(stall_cycles), 64'd10);

        // Watchdog with a held memory stall; stall counter saturates
        mem_stall_req = 1'b1;
        repeat (WDOG_LIMIT - 1) tick();
        chk("wd_before_limit", 64'(watchdog_err), 64'd0);
        tick();
        chk("wd_at_limit", 64'(watchdog_err), 64'd1);
        chk("cnt_saturated", 64'(stall_cycles), 64'd15);
        mem_stall_req = 1'b0;
        tick();
        tick();
        chk("wd_sticky", 64'(watchdog_err), 64'd1);
        chk("cnt_hold_sat", 64'(stall_cycles), 64'd15);
        chk_comb("wd_no_effect", 5'b00000, 5'b00000, 1'b0, 1'b0);

        // Reset while waiting on a fetch drops the latched redirect
        ex_redir_valid = 1'b1;
        ex_redir_pc = 64'h8000_0400;
        if_busy = 1'b1;
        tick();
        ex_redir_valid = 1'b0;
        #1 chk_comb("rst_pre_wait", 5'b00001, 5'b00110, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 chk_comb("rst_after", 5'b00000, 5'b00000, 1'b0, 1'b0);
        chk("rst_after_cnt", 64'(stall_cycles), 64'd0);
        chk("rst_after_wd", 64'(watchdog_err), 64'd0);
        if_busy = 1'b0;
        #1 chk("rst_no_redir", 64'(pc_redir_valid), 64'd0);
        chk("rst_no_addr", pc_redir_addr, 64'h0);
        tick();
        chk("rst_no_redir_later", 64'(pc_redir_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage in-order pipeline.
- Gathers stall requests from IF, ID, EX and MEM and the branch/jump redirect from EX.
- Drives per-register hold (stall_ctrl) and bubble (bubble_ctrl) vectors into pc_reg, if_id, id_ex, ex_mem and mem_wb, plus the PC redirect.
- Tracks stall statistics and a stuck-pipeline watchdog.

Parameters:
- PC_W, 64, width of PC / redirect address.
- WDOG_LIMIT, 1024, consecutive fully-stalled cycles before watchdog_err sets.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_stall_req  in  1  IF fetch not ready
- id_stall_req  in  1  load-use hazard
- ex_stall_req  in  1  multi-cycle mul/div busy
- mem_stall_req  in  1  data access not complete
- if_busy  in  1  instruction fetch outstanding on bus (cannot be cancelled)
- ex_redir_valid  in  1  EX requests redirect; held until ack
- ex_redir_pc  in  PC_W  redirect target
- ex_redir_ack  out  1  redirect accepted this cycle
- stall_ctrl  out  5  bit0 pc_reg, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb; 1 = hold
- bubble_ctrl  out  5  same bit mapping; 1 = load NOP/zero into that register this edge
- pc_redir_valid  out  1  pc_reg loads pc_redir_addr
- pc_redir_addr  out  PC_W  redirect PC
- stall_cycles  out  CNT_W  count of cycles with any stall_ctrl bit set; saturates
- watchdog_err  out  1  sticky stuck-pipeline flag

Behaviour:
- Reset, all values: stall_ctrl=5'b00000, bubble_ctrl=5'b00000, ex_redir_ack=0, pc_redir_valid=0, pc_redir_addr=0, stall_cycles=0, watchdog_err=0, FSM=RUN, wdog counter=0.
- Reset mid-operation drops any latched redirect.
- Stall priority is combinational in RUN; the oldest requesting stage wins:
  - mem_stall_req: stall=5'b01111, bubble=5'b10000.
  - else ex_stall_req: stall=5'b00111, bubble=5'b01000.
  - else id_stall_req: stall=5'b00011, bubble=5'b00100.
  - else if_stall_req: stall=5'b00001, bubble=5'b00010.
  - else all zero.
- Redirect accept condition: ex_redir_valid && !mem_stall_req && !ex_stall_req. Younger-stage stalls do not block it.
- On accept in RUN:
  - ex_redir_ack=1 that cycle; bubble |= 5'b00110 (flush if_id, id_ex).
  - Clear stall_ctrl bits 0-2 (redirect overrides id/if stalls).
  - If !if_busy: pc_redir_valid=1, pc_redir_addr=ex_redir_pc, same cycle; FSM stays RUN.
  - If if_busy: latch target into redir_q; FSM -> WAIT_FETCH.
- WAIT_FETCH:
  - Every cycle: stall_ctrl bit0=1, bubble bits1,2=1 (discard in-flight fetch); higher-stage stall rules still apply to bits 3,4.
  - ex_redir_ack=0; a new ex_redir_valid is not accepted.
  - When if_busy=0: pc_redir_valid=1, addr=redir_q; FSM -> RUN next edge.
- pc_redir_valid is a single-cycle pulse per accepted redirect; ex_redir_ack is a single-cycle pulse.
- stall_cycles: +1 each cycle stall_ctrl!=0; holds at all-ones.
- Watchdog counter:
  - Increments while stall_ctrl[4:3]!=0, or while in WAIT_FETCH; else clears.
  - At count==WDOG_LIMIT, watchdog_err<=1 and stays set until rst.
  - Pipeline behaviour is unaffected by watchdog_err.
- Registered elements: FSM, redir_q, counters, watchdog_err. stall_ctrl, bubble_ctrl, ack and redirect outputs are combinational from state + inputs (zero latency).

Decomposition:
- Shared defines file:
  - stage index constants (PC=0 .. WB=4).
  - STOP/NOSTOP encodings.
  - FSM state encodings RUN/WAIT_FETCH.
  - PC_W default.
- One natural sub-module: stall_prio_enc (combinational priority encoder from 4 requests to stall/bubble vectors); FSM, counters and watchdog stay in pipe_ctrl.

Test Plan:
- Requests mem=1,ex=1,id=1,if=1 in one cycle -> stall=01111, bubble=10000, stall_cycles+1; then drop mem only -> stall=00111, bubble=01000.
- ex_redir_valid=1, pc=0x8000_0100, if_busy=0, no stalls -> same cycle ack=1, pc_redir_valid=1, addr=0x8000_0100, bubble=00110.
- Redirect pc=0x8000_0200 with if_busy=1 for 3 cycles -> ack cycle 0; cycles 1-3 stall bit0=1, bubble bits1,2=1, pc_redir_valid=0; cycle when if_busy=0 -> pc_redir_valid=1 addr=0x8000_0200, then RUN.
- ex_redir_valid=1 while mem_stall_req=1 for 2 cycles -> ack=0, no redirect; ack and redirect in cycle after mem_stall_req drops.
- mem_stall_req held WDOG_LIMIT cycles (param 16) -> watchdog_err rises after the 16th; stays 1 after stall drops until rst.
- rst asserted in WAIT_FETCH -> next cycle all outputs zero, FSM RUN; later if_busy fall produces no pc_redir_valid.
